shift_pipe: RTL

Pipelined, handshaked barrel shifter that produces the shift results the downstream shift-check logic consumes. It accepts one data word, a shift amount of arbitrary width and a shift opcode per cycle, and returns the result a fixed three cycles later. Shift amounts at or beyond the data width saturate exactly as the language defines: logical shifts give zero, and arithmetic right shifts give sign fill.

---
 rtl/shift_pkg.sv | 19 +
 rtl/shift_pipe_stage.sv | 27 ++
 rtl/shift_pipe.sv | 121 ++++++++++++
 3 files changed

// File: rtl/shift_pkg.sv
// Shared opcode type and chunk constants for the shift_pipe barrel shifter.
package shift_pkg;

  typedef enum logic [1:0] {
    SRL = 2'd0,
    SRA = 2'd1,
    SLL = 2'd2,
    SLA = 2'd3
  } shift_op_t;

  localparam int unsigned SHIFT_CHUNK = 32;
  localparam int unsigned FINE_W      = $clog2(SHIFT_CHUNK);

  // SLL and SLA share the left-shift datapath.
  function automatic logic is_left(input shift_op_t op);
    return (op == SLL) || (op == SLA);
  endfunction

endpackage

// File: rtl/shift_pipe_stage.sv
// One pipeline register slice: valid bit plus payload, frozen while hold is high.
module shift_pipe_stage #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hold,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  // Bubbles advance the valid bit but leave the payload untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (!hold) begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_data <= in_data;
      end
    end
  end

endmodule

// File: rtl/shift_pipe.sv
// Three-stage handshaked barrel shifter: decode/saturate, 32-bit-chunk shift, fine shift.
// The result is visible after the third rising edge, counting the accepting edge.
module shift_pipe
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = 96,
  parameter int unsigned AMT_W = 96
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMT_W-1:0] in_amt,
  input  shift_op_t        in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  localparam int unsigned NCHUNK = WIDTH / SHIFT_CHUNK;
  localparam int unsigned EFF_W  = $clog2(WIDTH + 1);
  localparam int unsigned CMP_W  = (AMT_W > EFF_W) ? AMT_W : EFF_W;
  localparam int unsigned CRS_W  = $clog2(NCHUNK + 1);
  localparam int unsigned CSH_W  = CRS_W + FINE_W;
  localparam int unsigned S0_W   = WIDTH + 2 + CRS_W + FINE_W;
  localparam int unsigned S1_W   = WIDTH + 2 + FINE_W;

  // Shift by sh with zero fill on the left path and optional sign fill on the right path.
  function automatic logic [WIDTH-1:0] shift_fill(input logic [WIDTH-1:0] d,
                                                  input logic             left,
                                                  input logic             fill,
                                                  input logic [CSH_W-1:0] sh);
    logic [WIDTH-1:0] fill_mask;
    fill_mask = {WIDTH{fill}} & ~({WIDTH{1'b1}} >> sh);
    if (left) begin
      return d << sh;
    end
    return (d >> sh) | fill_mask;
  endfunction

  logic             stall;
  logic [CMP_W-1:0] amt_ext;
  logic             sat;
  logic [EFF_W-1:0] eff;

  logic [S0_W-1:0]   s0_d;
  logic [S0_W-1:0]   s0_q;
  logic              s0_v;
  logic [WIDTH-1:0]  s0_data;
  logic              s0_left;
  logic              s0_fill;
  logic [CRS_W-1:0]  s0_coarse;
  logic [FINE_W-1:0] s0_fine;

  logic [WIDTH-1:0]  c_data;
  logic [S1_W-1:0]   s1_d;
  logic [S1_W-1:0]   s1_q;
  logic              s1_v;
  logic [WIDTH-1:0]  s1_data;
  logic              s1_left;
  logic              s1_fill;
  logic [FINE_W-1:0] s1_fine;

  logic [WIDTH-1:0]  f_data;

  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;

  // Saturation compares every amount bit, so wide amounts are never truncated.
  assign amt_ext = CMP_W'(in_amt);
  assign sat     = amt_ext >= CMP_W'(WIDTH);
  assign eff     = sat ? EFF_W'(WIDTH) : EFF_W'(in_amt);

  assign s0_d = {in_data,
                 is_left(in_op),
                 (in_op == SRA) & in_data[WIDTH-1],
                 CRS_W'(eff >> FINE_W),
                 eff[FINE_W-1:0]};

  shift_pipe_stage #(.WIDTH(S0_W)) u_s0 (
    .clk       (clk),
    .rst       (rst),
    .hold      (stall),
    .in_valid  (in_valid),
    .in_data   (s0_d),
    .out_valid (s0_v),
    .out_data  (s0_q)
  );

  assign {s0_data, s0_left, s0_fill, s0_coarse, s0_fine} = s0_q;

  // Coarse step moves whole 32-bit chunks; coarse == NCHUNK yields pure fill.
  assign c_data = shift_fill(s0_data, s0_left, s0_fill, {s0_coarse, {FINE_W{1'b0}}});
  assign s1_d   = {c_data, s0_left, s0_fill, s0_fine};

  shift_pipe_stage #(.WIDTH(S1_W)) u_s1 (
    .clk       (clk),
    .rst       (rst),
    .hold      (stall),
    .in_valid  (s0_v),
    .in_data   (s1_d),
    .out_valid (s1_v),
    .out_data  (s1_q)
  );

  assign {s1_data, s1_left, s1_fill, s1_fine} = s1_q;

  assign f_data = shift_fill(s1_data, s1_left, s1_fill, CSH_W'(s1_fine));

  shift_pipe_stage #(.WIDTH(WIDTH)) u_s2 (
    .clk       (clk),
    .rst       (rst),
    .hold      (stall),
    .in_valid  (s1_v),
    .in_data   (f_data),
    .out_valid (out_valid),
    .out_data  (out_data)
  );

endmodule
